// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: ROM address/data, IF/ID slot toward decode, redirect from EX, debug status.
// The master modport belongs to fetch_ctrl; the slave modport is the ROM/decode/EX side.
interface fetch_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              id_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              flush;
    logic              halted;
    logic              misalign;
    logic [15:0]       fetch_count;
    logic [7:0]        redirect_count;

    modport master (
        output imem_addr, if_valid, if_instr, if_pc, flush, halted, misalign,
               fetch_count, redirect_count,
        input  imem_instr, id_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_addr, if_valid, if_instr, if_pc, flush, halted, misalign,
               fetch_count, redirect_count,
        output imem_instr, id_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC drives a zero-latency ROM and the word lands in IF/ID one cycle later.
// Slot holds while decode stalls (id_ready low); an EX redirect overrides the stall and costs two cycles.
module fetch_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter logic [ADDR_W-1:0] END_PC   = 8'hFC,
    parameter logic [31:0]       NOP      = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);
    typedef enum logic [0:0] {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_if_pc;
    logic [31:0]       r_if_instr;
    logic              r_if_valid;
    logic              r_flush;
    logic              r_misalign;
    logic [15:0]       r_fetch_cnt;
    logic [7:0]        r_redir_cnt;

    logic              w_load;
    logic              w_drain;
    logic              w_at_end;
    logic [ADDR_W-1:0] w_target;

    assign w_target = {bus.redirect_target[ADDR_W-1:2], 2'b00};
    assign w_at_end = (r_pc == END_PC);
    assign w_load   = (r_state == S_RUN) && !bus.redirect_valid
                      && (!r_if_valid || bus.id_ready);
    assign w_drain  = !bus.redirect_valid && !w_load && bus.id_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_valid)     w_state_nxt = S_RUN;
        else if (w_load && w_at_end) w_state_nxt = S_HALT;
    end

    always_comb begin
        bus.imem_addr      = r_pc;
        bus.if_valid       = r_if_valid;
        bus.if_instr       = r_if_instr;
        bus.if_pc          = r_if_pc;
        bus.flush          = r_flush;
        bus.halted         = (r_state == S_HALT);
        bus.misalign       = r_misalign;
        bus.fetch_count    = r_fetch_cnt;
        bus.redirect_count = r_redir_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_if_pc     <= '0;
            r_if_instr  <= NOP;
            r_if_valid  <= 1'b0;
            r_flush     <= 1'b0;
            r_misalign  <= 1'b0;
            r_fetch_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            r_flush <= bus.redirect_valid;
            if (bus.redirect_valid) begin
                r_pc       <= w_target;
                r_if_valid <= 1'b0;
                r_if_instr <= NOP;
                r_misalign <= r_misalign | (|bus.redirect_target[1:0]);
                if (r_redir_cnt != 8'hFF) r_redir_cnt <= r_redir_cnt + 8'd1;
            end else if (w_load) begin
                r_if_instr <= bus.imem_instr;
                r_if_pc    <= r_pc;
                r_if_valid <= 1'b1;
                // The last program word parks the PC so imem_addr stays on END_PC while halted.
                if (!w_at_end) r_pc <= r_pc + ADDR_W'(4);
                if (r_fetch_cnt != 16'hFFFF) r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end else if (w_drain) begin
                r_if_valid <= 1'b0;
                r_if_instr <= NOP;
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: three instances (default END_PC, END_PC=0C, END_PC never reached).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl_if #(.ADDR_W(8)) a_if ();
    fetch_ctrl_if #(.ADDR_W(8)) b_if ();
    fetch_ctrl_if #(.ADDR_W(8)) c_if ();

    fetch_ctrl u_a (.clk(clk), .reset(rst_a), .bus(a_if.master));
    fetch_ctrl #(.END_PC(8'h0C)) u_b (.clk(clk), .reset(rst_b), .bus(b_if.master));
    fetch_ctrl #(.END_PC(8'hFD)) u_c (.clk(clk), .reset(rst_c), .bus(c_if.master));

    function automatic logic [31:0] rom(input logic [7:0] a);
        case (a)
            8'h00:   rom = 32'h00c08093;
            8'h04:   rom = 32'h00010463;
            8'h08:   rom = 32'h00f10113;
            8'h0C:   rom = 32'h00103023;
            default: rom = 32'hA000_0000 | {24'h0, a};
        endcase
    endfunction

    assign a_if.imem_instr = rom(a_if.imem_addr);
    assign b_if.imem_instr = rom(b_if.imem_addr);
    assign c_if.imem_instr = rom(c_if.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, ".valid"}, 32'(a_if.if_valid), 32'd0);
        chk({tag, ".instr"}, a_if.if_instr, NOP);
        chk({tag, ".if_pc"}, 32'(a_if.if_pc), 32'd0);
        chk({tag, ".addr"}, 32'(a_if.imem_addr), 32'd0);
        chk({tag, ".flush"}, 32'(a_if.flush), 32'd0);
        chk({tag, ".halted"}, 32'(a_if.halted), 32'd0);
        chk({tag, ".misalign"}, 32'(a_if.misalign), 32'd0);
        chk({tag, ".fcnt"}, 32'(a_if.fetch_count), 32'd0);
        chk({tag, ".rcnt"}, 32'(a_if.redirect_count), 32'd0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_if.id_ready = 1'b1; a_if.redirect_valid = 1'b0; a_if.redirect_target = 8'h00;
        b_if.id_ready = 1'b1; b_if.redirect_valid = 1'b0; b_if.redirect_target = 8'h00;
        c_if.id_ready = 1'b1; c_if.redirect_valid = 1'b0; c_if.redirect_target = 8'h00;

        @(negedge clk);
        chk_a_reset("rst");

        // Straight-line fetch of four words
        rst_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("run.valid", 32'(a_if.if_valid), 32'd1);
            chk("run.if_pc", 32'(a_if.if_pc), 32'(4 * k));
            chk("run.instr", a_if.if_instr, rom(8'(4 * k)));
            chk("run.fcnt", 32'(a_if.fetch_count), 32'(k + 1));
        end
        chk("run.addr", 32'(a_if.imem_addr), 32'h10);

        // Fresh start, then stall with pc=4 in the slot
        rst_a = 1'b1;
        #1;
        chk("rst2.valid", 32'(a_if.if_valid), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        chk("st.pc0", 32'(a_if.if_pc), 32'h0);
        @(negedge clk);
        chk("st.pc4", 32'(a_if.if_pc), 32'h4);
        a_if.id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("st.instr", a_if.if_instr, 32'h00010463);
            chk("st.if_pc", 32'(a_if.if_pc), 32'h4);
            chk("st.addr", 32'(a_if.imem_addr), 32'h8);
            chk("st.fcnt", 32'(a_if.fetch_count), 32'd2);
        end
        a_if.id_ready = 1'b1;
        @(negedge clk);
        chk("st.resume_pc", 32'(a_if.if_pc), 32'h8);
        chk("st.resume_fcnt", 32'(a_if.fetch_count), 32'd3);

        // Redirect to 0C while slot holds pc=8
        a_if.redirect_valid = 1'b1; a_if.redirect_target = 8'h0C;
        @(negedge clk);
        a_if.redirect_valid = 1'b0;
        chk("rd.valid", 32'(a_if.if_valid), 32'd0);
        chk("rd.instr", a_if.if_instr, NOP);
        chk("rd.flush", 32'(a_if.flush), 32'd1);
        chk("rd.addr", 32'(a_if.imem_addr), 32'h0C);
        chk("rd.rcnt", 32'(a_if.redirect_count), 32'd1);
        @(negedge clk);
        chk("rd.flush_off", 32'(a_if.flush), 32'd0);
        chk("rd.if_pc", 32'(a_if.if_pc), 32'h0C);
        chk("rd.instr2", a_if.if_instr, 32'h00103023);
        chk("rd.fcnt", 32'(a_if.fetch_count), 32'd4);

        // Misaligned redirect during a stall, then an aligned back-to-back redirect
        a_if.id_ready = 1'b0;
        @(negedge clk);
        chk("rs.hold_pc", 32'(a_if.if_pc), 32'h0C);
        chk("rs.hold_addr", 32'(a_if.imem_addr), 32'h10);
        a_if.redirect_valid = 1'b1; a_if.redirect_target = 8'h0D;
        @(negedge clk);
        chk("rs.addr", 32'(a_if.imem_addr), 32'h0C);
        chk("rs.misalign", 32'(a_if.misalign), 32'd1);
        chk("rs.valid", 32'(a_if.if_valid), 32'd0);
        chk("rs.flush", 32'(a_if.flush), 32'd1);
        chk("rs.rcnt", 32'(a_if.redirect_count), 32'd2);
        a_if.redirect_target = 8'h08;
        @(negedge clk);
        a_if.redirect_valid = 1'b0;
        chk("rs2.addr", 32'(a_if.imem_addr), 32'h08);
        chk("rs2.flush", 32'(a_if.flush), 32'd1);
        chk("rs2.misalign", 32'(a_if.misalign), 32'd1);
        chk("rs2.rcnt", 32'(a_if.redirect_count), 32'd3);
        @(negedge clk);
        chk("rs3.flush", 32'(a_if.flush), 32'd0);
        chk("rs3.if_pc", 32'(a_if.if_pc), 32'h08);
        chk("rs3.instr", a_if.if_instr, 32'h00f10113);
        chk("rs3.misalign", 32'(a_if.misalign), 32'd1);
        chk("rs3.fcnt", 32'(a_if.fetch_count), 32'd5);

        // Asynchronous reset while stalled with a live slot
        #2;
        rst_a = 1'b1;
        #1;
        chk_a_reset("arst");

        // END_PC=0C instance: halt, hold, then redirect out of HALT
        @(negedge clk);
        rst_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("end.if_pc", 32'(b_if.if_pc), 32'(4 * k));
        end
        chk("end.halted", 32'(b_if.halted), 32'd1);
        chk("end.addr", 32'(b_if.imem_addr), 32'h0C);
        chk("end.fcnt", 32'(b_if.fetch_count), 32'd4);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("hlt.halted", 32'(b_if.halted), 32'd1);
            chk("hlt.addr", 32'(b_if.imem_addr), 32'h0C);
            chk("hlt.fcnt", 32'(b_if.fetch_count), 32'd4);
            chk("hlt.valid", 32'(b_if.if_valid), 32'd0);
        end
        b_if.redirect_valid = 1'b1; b_if.redirect_target = 8'h00;
        @(negedge clk);
        b_if.redirect_valid = 1'b0;
        chk("unhlt.halted", 32'(b_if.halted), 32'd0);
        chk("unhlt.addr", 32'(b_if.imem_addr), 32'h00);
        chk("unhlt.flush", 32'(b_if.flush), 32'd1);
        @(negedge clk);
        chk("unhlt.if_pc", 32'(b_if.if_pc), 32'h00);
        chk("unhlt.valid", 32'(b_if.if_valid), 32'd1);
        chk("unhlt.instr", b_if.if_instr, 32'h00c08093);
        chk("unhlt.fcnt", 32'(b_if.fetch_count), 32'd5);

        // Free-running instance: PC wrap and fetch_count saturation
        rst_c = 1'b0;
        for (int k = 1; k <= 65540; k++) begin
            @(negedge clk);
            if (k == 64) begin
                chk("wrap.if_pc", 32'(c_if.if_pc), 32'hFC);
                chk("wrap.addr", 32'(c_if.imem_addr), 32'h00);
                chk("wrap.fcnt", 32'(c_if.fetch_count), 32'd64);
            end
            if (k == 65534) chk("sat.pre", 32'(c_if.fetch_count), 32'hFFFE);
            if (k == 65535) chk("sat.hit", 32'(c_if.fetch_count), 32'hFFFF);
        end
        chk("sat.end", 32'(c_if.fetch_count), 32'hFFFF);
        chk("sat.valid", 32'(c_if.if_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the 5-stage core. Owns the PC and drives the byte address into the combinational 64x32 instruction ROM. Registers the returned word plus its PC into the IF/ID slot under a valid/ready handshake. Applies branch/jump redirects from EX, generates the flush pulse, detects end of program and keeps saturating fetch/redirect counters for debug.

Parameters:
ADDR_W, 8, byte-address width of PC and ROM address
RESET_PC, 8'h00, PC loaded on reset
END_PC, 8'hFC, address of last program word; fetch stops after it is accepted
NOP, 32'h00000013, value held in if_instr when slot is invalid

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
imem_addr  out  ADDR_W  byte address to ROM (= pc register, combinational)
imem_instr  in  32  ROM read data, valid same cycle as imem_addr
if_valid  out  1  IF/ID slot holds a live instruction
if_instr  out  32  IF/ID instruction
if_pc  out  ADDR_W  PC of if_instr
id_ready  in  1  decode accepts slot this cycle (low = hazard stall)
redirect_valid  in  1  EX resolved taken branch/jump
redirect_target  in  ADDR_W  byte target of redirect
flush  out  1  registered one-cycle pulse: younger instructions killed
halted  out  1  fetch stopped at END_PC
misalign  out  1  sticky: a redirect target had [1:0] != 0
fetch_count  out  16  saturating count of words loaded into IF/ID
redirect_count  out  8  saturating count of redirects taken

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=RUN, if_valid=0, if_instr=NOP, if_pc=0, flush=0, halted=0, misalign=0, counters=0.
- States: RUN, HALT. Reset -> RUN.
- imem_addr = pc always, including HALT. ROM latency is 0, so fetch-to-slot latency is 1 cycle.
- Slot load condition in RUN: redirect_valid=0 and (if_valid=0 or id_ready=1).
  - On load: if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^ADDR_W), fetch_count++ (saturates at 16'hFFFF).
- Slot drains when id_ready=1 and no load: if_valid<=0, if_instr<=NOP.
- Stall (if_valid=1, id_ready=0, no redirect): pc, slot and counters hold.
- Redirect (redirect_valid=1), any state, highest priority, overrides stall:
  - pc<=redirect_target & ~3. Bits [1:0] are forced to 0; misalign<=1 if they were nonzero.
  - if_valid<=0, if_instr<=NOP (slot killed).
  - flush<=1 next cycle only; flush=0 every other cycle.
  - redirect_count++ (saturates at 8'hFF).
  - State -> RUN, halted<=0.
  - The target word is loaded into the slot at the following edge (2-cycle redirect penalty).
  - A redirect held for consecutive cycles re-applies each cycle, with flush staying high.
- End of program: when a load occurs with pc==END_PC:
  - State -> HALT, halted<=1.
  - pc holds at END_PC (does not advance or wrap).
  - The slot still drains normally via id_ready.
- HALT: no loads, counters hold. Only a redirect or reset leaves HALT.
- PC wrap: pc+4 at 8'hFC gives 8'h00. This is unreachable when END_PC=8'hFC, which halts first.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately; no flush pulse is produced.

Test Plan:
- Reset then run, id_ready=1, ROM[0..3] = 00c08093, 00010463, 00f10113, 00103023 -> if_pc 0,4,8,C on consecutive cycles starting 1 cycle after reset release; fetch_count=4 after 4 loads.
- Stall: with if_pc=4 live, drop id_ready for 3 cycles -> if_instr=00010463, if_pc=4, imem_addr=8 all held; resume -> if_pc=8 next cycle.
- Redirect at cycle t with target 8'h0C while slot holds pc=8 -> if_valid=0 at t+1, flush=1 at t+1 only, if_pc=0C at t+2, redirect_count=1.
- Redirect during stall (id_ready=0), target 8'h0D -> redirect wins, pc=0C, misalign=1 and remains 1 after later aligned redirects.
- END_PC=8'h0C: after 4 loads -> halted=1, imem_addr stays 0C, fetch_count=4 frozen; redirect to 8'h00 -> halted=0, fetch resumes from 0.
- Assert reset while stalled with if_valid=1 -> all outputs at reset values without waiting for a clock edge; fetch_count saturation checked by forcing 65540 loads -> stays FFFF.
